// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and parity helper for the uart_xcvr transceiver
package uart_pkg;

  // Widest payload the core supports; parity helper works on this width.
  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    EVEN = 2'b01,
    ODD  = 2'b10,
    RSVD = 2'b11
  } parity_mode_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_DONE
  } rx_state_e;

  // RSVD behaves like NONE: no parity bit on the wire.
  function automatic logic parity_enabled(parity_mode_e mode);
    return (mode == EVEN) || (mode == ODD);
  endfunction

  // Zero-extended data does not change the XOR, so narrower payloads are safe.
  function automatic logic parity_bit(logic [MAX_DATA_BITS-1:0] data, parity_mode_e mode);
    logic p;
    p = 1'b0;
    if (mode == EVEN) p = ^data;
    else if (mode == ODD) p = ~(^data);
    return p;
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// rtl/uart_tick_gen.sv - oversampling tick prescaler with restart and wrap-time divisor reload
module uart_tick_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DIV_WIDTH-1:0] divisor_i,
  input  logic                 restart_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] div_q;

  // A restart suppresses the tick so the first tick of a new frame lands a full period later.
  assign tick_o = !restart_i && (cnt_q == div_q);

  // Count 0..div_q; the divisor is only picked up at a wrap or restart so a period is never cut short.
  always_ff @(posedge clk_i) begin
    if (rst_i || restart_i) begin
      cnt_q <= '0;
      div_q <= divisor_i;
    end else if (cnt_q == div_q) begin
      cnt_q <= '0;
      div_q <= divisor_i;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_xcvr.sv
// rtl/uart_xcvr.sv - full-duplex UART transceiver with oversampled RX, parity, loopback and error reporting
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 SysClk,
  input  logic                 Rst,
  input  logic [DIV_WIDTH-1:0] Divisor,
  input  logic [1:0]           Parity_Mode,
  input  logic                 Loopback,
  input  logic [DATA_BITS-1:0] Tx_Data,
  input  logic                 Tx_Valid,
  output logic                 Tx_Ready,
  input  logic                 CTS,
  output logic                 Tx,
  output logic                 Tx_Busy,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 Rx_Valid,
  input  logic                 Rx_Ready,
  output logic                 Parity_Err,
  output logic                 Frame_Err,
  output logic                 Overrun_Err,
  output logic                 Break_Det,
  output logic                 RTS
);

  localparam int              OS_W      = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);

  // ---------------- transmitter ----------------
  tx_state_e              tx_state_q;
  logic                   tx_q;
  logic [DATA_BITS-1:0]   tx_shift_q;
  logic [3:0]             tx_bit_q;
  logic [OS_W-1:0]        tx_os_q;
  logic                   tx_par_en_q;
  logic                   tx_par_q;
  logic                   tx_tick;
  logic                   tx_xfer;
  parity_mode_e           tx_mode;

  assign tx_mode  = parity_mode_e'(Parity_Mode);
  assign Tx_Ready = (tx_state_q == TX_IDLE) && CTS && !Rst;
  assign tx_xfer  = Tx_Valid && Tx_Ready;
  assign Tx_Busy  = (tx_state_q != TX_IDLE);
  assign Tx       = Loopback ? 1'b1 : tx_q;

  uart_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tx_tick (
    .clk_i     (SysClk),
    .rst_i     (Rst),
    .divisor_i (Divisor),
    .restart_i (tx_xfer),
    .tick_o    (tx_tick)
  );

  // TX FSM: each bit holds for OVERSAMPLE ticks; tx_q is the registered line level.
  always_ff @(posedge SysClk) begin
    if (Rst) begin
      tx_state_q  <= TX_IDLE;
      tx_q        <= 1'b1;
      tx_shift_q  <= '0;
      tx_bit_q    <= '0;
      tx_os_q     <= '0;
      tx_par_en_q <= 1'b0;
      tx_par_q    <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_xfer) begin
            tx_shift_q  <= Tx_Data;
            tx_par_en_q <= parity_enabled(tx_mode);
            tx_par_q    <= parity_bit(MAX_DATA_BITS'(Tx_Data), tx_mode);
            tx_q        <= 1'b0;
            tx_os_q     <= '0;
            tx_bit_q    <= '0;
            tx_state_q  <= TX_START;
          end
        end
        default: begin
          if (tx_tick) begin
            if (tx_os_q != OS_LAST) begin
              tx_os_q <= tx_os_q + 1'b1;
            end else begin
              tx_os_q <= '0;
              case (tx_state_q)
                TX_START: begin
                  tx_q       <= tx_shift_q[0];
                  tx_shift_q <= tx_shift_q >> 1;
                  tx_bit_q   <= '0;
                  tx_state_q <= TX_DATA;
                end
                TX_DATA: begin
                  if (tx_bit_q == DATA_LAST) begin
                    tx_bit_q <= '0;
                    if (tx_par_en_q) begin
                      tx_q       <= tx_par_q;
                      tx_state_q <= TX_PARITY;
                    end else begin
                      tx_q       <= 1'b1;
                      tx_state_q <= TX_STOP;
                    end
                  end else begin
                    tx_q       <= tx_shift_q[0];
                    tx_shift_q <= tx_shift_q >> 1;
                    tx_bit_q   <= tx_bit_q + 1'b1;
                  end
                end
                TX_PARITY: begin
                  tx_q       <= 1'b1;
                  tx_bit_q   <= '0;
                  tx_state_q <= TX_STOP;
                end
                TX_STOP: begin
                  if (tx_bit_q == STOP_LAST) tx_state_q <= TX_IDLE;
                  else                       tx_bit_q   <= tx_bit_q + 1'b1;
                end
                default: tx_state_q <= TX_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic                 rx_in;
  logic                 sync1_q, sync2_q, rx_last_q;
  logic                 lb_q;
  logic                 lb_change;
  logic                 rx_fall;
  logic                 rx_restart;
  logic                 rx_tick;
  rx_state_e            rx_state_q;
  logic [OS_W-1:0]      rx_os_q;
  logic [3:0]           rx_bit_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 rx_par_q;
  logic                 rx_stop_q;
  parity_mode_e         rx_mode_q;
  logic                 rx_brk_wait_q;
  logic                 rx_valid_q, rx_valid_d;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 perr_q, ferr_q, ovr_q, brk_q, rts_q;
  logic                 rx_done, rx_deliver, rx_overrun, rx_is_break, rx_perr;

  assign rx_in      = Loopback ? tx_q : Rx;
  assign lb_change  = (Loopback != lb_q);
  assign rx_fall    = rx_last_q && !sync2_q;
  assign rx_restart = (rx_state_q == RX_IDLE) && rx_fall && !rx_brk_wait_q && !lb_change;

  assign rx_done     = (rx_state_q == RX_DONE) && !lb_change;
  assign rx_deliver  = rx_done && (!rx_valid_q || Rx_Ready);
  assign rx_overrun  = rx_done && rx_valid_q && !Rx_Ready;
  assign rx_is_break = (rx_shift_q == '0) && !rx_stop_q;
  assign rx_perr     = parity_enabled(rx_mode_q) && !rx_is_break &&
                       (rx_par_q != parity_bit(MAX_DATA_BITS'(rx_shift_q), rx_mode_q));

  uart_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_rx_tick (
    .clk_i     (SysClk),
    .rst_i     (Rst),
    .divisor_i (Divisor),
    .restart_i (rx_restart),
    .tick_o    (rx_tick)
  );

  // Two-flop synchroniser on the muxed line plus a delayed copy for edge detection.
  always_ff @(posedge SysClk) begin
    if (Rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_last_q <= 1'b1;
    end else begin
      sync1_q   <= rx_in;
      sync2_q   <= sync1_q;
      rx_last_q <= sync2_q;
    end
  end

  // Rx_Valid next state: a take clears it, a delivery (possibly in the same cycle) sets it.
  always_comb begin
    rx_valid_d = rx_valid_q;
    if (rx_valid_q && Rx_Ready) rx_valid_d = 1'b0;
    if (rx_deliver)             rx_valid_d = 1'b1;
  end

  // RX FSM and output registers: mid-bit sampling, completion handling and error pulses.
  always_ff @(posedge SysClk) begin
    if (Rst) begin
      rx_state_q    <= RX_IDLE;
      rx_os_q       <= '0;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      rx_par_q      <= 1'b0;
      rx_stop_q     <= 1'b1;
      rx_mode_q     <= NONE;
      rx_brk_wait_q <= 1'b0;
      lb_q          <= Loopback;
      rx_valid_q    <= 1'b0;
      rx_data_q     <= '0;
      perr_q        <= 1'b0;
      ferr_q        <= 1'b0;
      ovr_q         <= 1'b0;
      brk_q         <= 1'b0;
      rts_q         <= 1'b1;
    end else begin
      lb_q       <= Loopback;
      rx_valid_q <= rx_valid_d;
      rts_q      <= !rx_valid_d;
      ovr_q      <= rx_overrun;
      brk_q      <= rx_done && rx_is_break;
      if (rx_deliver) begin
        rx_data_q <= rx_shift_q;
        perr_q    <= rx_perr;
        ferr_q    <= !rx_stop_q;
      end
      if (lb_change) begin
        rx_state_q <= RX_IDLE;
        rx_os_q    <= '0;
      end else begin
        case (rx_state_q)
          RX_IDLE: begin
            if (rx_brk_wait_q && sync2_q) rx_brk_wait_q <= 1'b0;
            if (rx_restart) begin
              rx_os_q    <= '0;
              rx_mode_q  <= parity_mode_e'(Parity_Mode);
              rx_state_q <= RX_START;
            end
          end
          RX_START: begin
            if (rx_tick) begin
              if (rx_os_q != OS_HALF) begin
                rx_os_q <= rx_os_q + 1'b1;
              end else begin
                rx_os_q  <= '0;
                rx_bit_q <= '0;
                rx_state_q <= sync2_q ? RX_IDLE : RX_DATA;
              end
            end
          end
          RX_DATA, RX_PARITY, RX_STOP: begin
            if (rx_tick) begin
              if (rx_os_q != OS_LAST) begin
                rx_os_q <= rx_os_q + 1'b1;
              end else begin
                rx_os_q <= '0;
                if (rx_state_q == RX_DATA) begin
                  rx_shift_q <= {sync2_q, rx_shift_q[DATA_BITS-1:1]};
                  if (rx_bit_q == DATA_LAST)
                    rx_state_q <= parity_enabled(rx_mode_q) ? RX_PARITY : RX_STOP;
                  else
                    rx_bit_q <= rx_bit_q + 1'b1;
                end else if (rx_state_q == RX_PARITY) begin
                  rx_par_q   <= sync2_q;
                  rx_state_q <= RX_STOP;
                end else begin
                  rx_stop_q  <= sync2_q;
                  rx_state_q <= RX_DONE;
                end
              end
            end
          end
          RX_DONE: begin
            if (rx_is_break) rx_brk_wait_q <= 1'b1;
            rx_state_q <= RX_IDLE;
          end
          default: rx_state_q <= RX_IDLE;
        endcase
      end
    end
  end

  assign Rx_Data     = rx_data_q;
  assign Rx_Valid    = rx_valid_q;
  assign Parity_Err  = perr_q;
  assign Frame_Err   = ferr_q;
  assign Overrun_Err = ovr_q;
  assign Break_Det   = brk_q;
  assign RTS         = rts_q;

endmodule

// File: tb/tb_uart_xcvr.sv
// tb/tb_uart_xcvr.sv - scoreboard bench for uart_xcvr with a frame-level reference model
module tb_uart_xcvr;

  logic        SysClk;
  logic        Rst;
  logic [15:0] Divisor;
  logic [1:0]  Parity_Mode;
  logic        Loopback;
  logic [7:0]  Tx_Data;
  logic        Tx_Valid;
  logic        Tx_Ready;
  logic        CTS;
  logic        Tx;
  logic        Tx_Busy;
  logic        Rx;
  logic [7:0]  Rx_Data;
  logic        Rx_Valid;
  logic        Rx_Ready;
  logic        Parity_Err;
  logic        Frame_Err;
  logic        Overrun_Err;
  logic        Break_Det;
  logic        RTS;

  uart_xcvr dut (
    .SysClk(SysClk), .Rst(Rst), .Divisor(Divisor), .Parity_Mode(Parity_Mode),
    .Loopback(Loopback), .Tx_Data(Tx_Data), .Tx_Valid(Tx_Valid), .Tx_Ready(Tx_Ready),
    .CTS(CTS), .Tx(Tx), .Tx_Busy(Tx_Busy), .Rx(Rx), .Rx_Data(Rx_Data),
    .Rx_Valid(Rx_Valid), .Rx_Ready(Rx_Ready), .Parity_Err(Parity_Err),
    .Frame_Err(Frame_Err), .Overrun_Err(Overrun_Err), .Break_Det(Break_Det), .RTS(RTS)
  );

  initial begin
    SysClk = 1'b0;
    forever #5 SysClk = ~SysClk;
  end

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ovr_cnt = 0, ovr_long = 0, brk_cnt = 0, brk_long = 0, rxv_cycles = 0, lb_bad = 0;
  logic ovr_prev = 1'b0, brk_prev = 1'b0;
  bit   rdy_rand = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge SysClk);
    #1;
  endtask

  function automatic logic model_parity(logic [7:0] d, logic [1:0] mode);
    int ones;
    ones = $countones(d);
    if (mode == 2'd1) return logic'(ones % 2);
    if (mode == 2'd2) return logic'(1 - ones % 2);
    return 1'b0;
  endfunction

  // Expected serial level k cycles after the accepting cycle, bit period bc cycles.
  function automatic logic tx_level(logic [7:0] d, logic [1:0] mode, int k, int bc);
    int idx;
    idx = (k - 1) / bc;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9 && (mode == 2'd1 || mode == 2'd2)) return model_parity(d, mode);
    return 1'b1;
  endfunction

  // Scoreboard monitor: pops an expectation on every accepted byte; also tallies pulses.
  always @(negedge SysClk) begin
    exp_t e;
    if (Overrun_Err) begin
      ovr_cnt++;
      if (ovr_prev) ovr_long++;
    end
    if (Break_Det) begin
      brk_cnt++;
      if (brk_prev) brk_long++;
    end
    ovr_prev = Overrun_Err;
    brk_prev = Break_Det;
    if (Rx_Valid) rxv_cycles++;
    if (Loopback && Tx !== 1'b1) lb_bad++;
    if (Rx_Valid && Rx_Ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected: got byte 0x%0h expected no byte", Rx_Data);
      end else begin
        e = sb.pop_front();
        check("rx_data", {24'h0, Rx_Data}, {24'h0, e.data});
        check("rx_parity_err", {31'h0, Parity_Err}, {31'h0, e.perr});
        check("rx_frame_err", {31'h0, Frame_Err}, {31'h0, e.ferr});
      end
    end
  end

  initial begin
    forever begin
      tick();
      if (rdy_rand) Rx_Ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    repeat (90000) @(posedge SysClk);
    $display("FAIL watchdog: got cycle budget exhausted expected test end");
    $fatal(1, "timeout");
  end

  task automatic rx_frame(input logic [7:0] d, input logic [1:0] mode, input bit corrupt);
    logic bits[$];
    int   bc;
    bc = 16 * (int'(Divisor) + 1);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (mode == 2'd1 || mode == 2'd2) bits.push_back(model_parity(d, mode) ^ corrupt);
    bits.push_back(1'b1);
    foreach (bits[i]) begin
      tick();
      Rx = bits[i];
      repeat (bc - 1) tick();
    end
  endtask

  task automatic tx_send(input logic [7:0] d);
    int n;
    n = 0;
    tick();
    Tx_Data  = d;
    Tx_Valid = 1'b1;
    @(negedge SysClk);
    while (!Tx_Ready && n < 2000) begin
      @(negedge SysClk);
      n++;
    end
    check("tx_accept", {31'h0, Tx_Ready}, 32'h1);
    tick();
    Tx_Valid = 1'b0;
    n = 0;
    while (Tx_Busy && n < 5000) begin
      tick();
      n++;
    end
    check("tx_done", {31'h0, Tx_Busy}, 32'h0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    check("rx_drain", sb.size(), 0);
  endtask

  initial begin
    int       bad_tx, bad_rdy, o0, b0, v0;
    logic [7:0] d;
    logic [1:0] mode;
    bit       use_lb, corrupt;

    Rst = 1'b1; Divisor = 16'd0; Parity_Mode = 2'd0; Loopback = 1'b0;
    Tx_Data = 8'h00; Tx_Valid = 1'b0; CTS = 1'b1; Rx = 1'b1; Rx_Ready = 1'b1;
    repeat (3) tick();
    @(negedge SysClk);
    check("rst_tx", {31'h0, Tx}, 32'h1);
    check("rst_busy", {31'h0, Tx_Busy}, 32'h0);
    check("rst_rx_valid", {31'h0, Rx_Valid}, 32'h0);
    check("rst_rx_data", {24'h0, Rx_Data}, 32'h0);
    check("rst_errs", {28'h0, Parity_Err, Frame_Err, Overrun_Err, Break_Det}, 32'h0);
    check("rst_rts", {31'h0, RTS}, 32'h1);
    check("rst_tx_ready", {31'h0, Tx_Ready}, 32'h0);
    tick();
    Rst = 1'b0;
    repeat (4) tick();

    // 8N1 at Divisor=0: exact waveform of 0xA5 and ready window.
    Tx_Data = 8'hA5; Tx_Valid = 1'b1;
    fork begin tick(); Tx_Valid = 1'b0; end join_none
    bad_tx = 0; bad_rdy = 0;
    for (int k = 0; k <= 165; k++) begin
      @(negedge SysClk);
      if (k == 0) begin
        check("a5_accept", {31'h0, Tx_Ready}, 32'h1);
      end else begin
        if (Tx !== tx_level(8'hA5, 2'd0, k, 16)) bad_tx++;
        if (Tx_Ready !== (k >= 161)) bad_rdy++;
        if (k == 1)   check("a5_start_low", {31'h0, Tx}, 32'h0);
        if (k == 145) check("a5_stop_high", {31'h0, Tx}, 32'h1);
        if (k == 160) check("a5_ready_t160", {31'h0, Tx_Ready}, 32'h0);
        if (k == 161) check("a5_ready_t161", {31'h0, Tx_Ready}, 32'h1);
      end
    end
    check("a5_wave", bad_tx, 0);
    check("a5_ready_window", bad_rdy, 0);

    // Loopback, even parity.
    tick();
    Loopback = 1'b1; Parity_Mode = 2'd1;
    repeat (4) tick();
    lb_bad = 0;
    sb.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b0});
    tx_send(8'h3C);
    wait_drain();
    check("lb_tx_pin_high", lb_bad, 0);

    // Corrupted even parity on the pin.
    Loopback = 1'b0;
    repeat (4) tick();
    sb.push_back('{data: 8'h3C, perr: 1'b1, ferr: 1'b0});
    rx_frame(8'h3C, 2'd1, 1'b1);
    wait_drain();

    // Overrun: two frames while the consumer stalls.
    Parity_Mode = 2'd0; Rx_Ready = 1'b0;
    repeat (4) tick();
    o0 = ovr_cnt;
    sb.push_back('{data: 8'h11, perr: 1'b0, ferr: 1'b0});
    rx_frame(8'h11, 2'd0, 1'b0);
    rx_frame(8'h22, 2'd0, 1'b0);
    repeat (40) tick();
    @(negedge SysClk);
    check("ovr_pulses", ovr_cnt - o0, 1);
    check("ovr_single_cycle", ovr_long, 0);
    check("ovr_keep_data", {24'h0, Rx_Data}, 32'h11);
    check("ovr_valid_held", {31'h0, Rx_Valid}, 32'h1);
    check("ovr_rts_low", {31'h0, RTS}, 32'h0);
    tick();
    Rx_Ready = 1'b1;
    tick();
    @(negedge SysClk);
    check("ovr_valid_clear", {31'h0, Rx_Valid}, 32'h0);
    check("ovr_rts_high", {31'h0, RTS}, 32'h1);
    check("ovr_sb_empty", sb.size(), 0);

    // Three-cycle glitch: no byte, no flags.
    o0 = ovr_cnt; b0 = brk_cnt; v0 = rxv_cycles;
    tick(); Rx = 1'b0;
    repeat (3) tick();
    Rx = 1'b1;
    repeat (60) tick();
    check("glitch_no_valid", rxv_cycles - v0, 0);
    check("glitch_no_ovr", ovr_cnt - o0, 0);
    check("glitch_no_brk", brk_cnt - b0, 0);

    // Break: twelve bit times low.
    b0 = brk_cnt;
    sb.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1});
    tick(); Rx = 1'b0;
    repeat (12 * 16 - 1) tick();
    check("brk_pulses", brk_cnt - b0, 1);
    check("brk_single_cycle", brk_long, 0);
    check("brk_delivered", sb.size(), 0);
    Rx = 1'b1;
    repeat (40) tick();
    check("brk_no_restart", sb.size(), 0);

    // Randomised frames through the pin and through loopback.
    for (int it = 0; it < 10; it++) begin
      d       = 8'($urandom);
      mode    = 2'($urandom_range(0, 3));
      use_lb  = 1'($urandom_range(0, 1));
      corrupt = use_lb ? 1'b0 : 1'($urandom_range(0, 1));
      tick();
      Divisor = 16'($urandom_range(0, 2));
      Parity_Mode = mode;
      Loopback = use_lb;
      repeat (8) tick();
      rdy_rand = 1;
      sb.push_back('{data: d, perr: corrupt && (mode == 2'd1 || mode == 2'd2), ferr: 1'b0});
      if (use_lb) tx_send(d);
      else        rx_frame(d, mode, corrupt);
      wait_drain();
      rdy_rand = 0;
      tick(); tick();
      Rx_Ready = 1'b1;
    end

    // Divisor=3, CTS gating, then reset mid-frame.
    tick();
    Loopback = 1'b0; Parity_Mode = 2'd0; Divisor = 16'd3; CTS = 1'b0;
    Tx_Data = 8'h5B; Tx_Valid = 1'b1;
    bad_tx = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge SysClk);
      if (Tx_Ready !== 1'b0 || Tx !== 1'b1) bad_tx++;
    end
    check("cts_block", bad_tx, 0);
    tick();
    CTS = 1'b1;
    fork begin tick(); Tx_Valid = 1'b0; end join_none
    bad_tx = 0;
    for (int k = 0; k <= 150; k++) begin
      @(negedge SysClk);
      if (k == 0) check("d3_accept", {31'h0, Tx_Ready}, 32'h1);
      else if (Tx !== tx_level(8'h5B, 2'd0, k, 64)) bad_tx++;
      if (k == 64)  check("d3_start_end", {31'h0, Tx}, 32'h0);
      if (k == 65)  check("d3_bit0_begin", {31'h0, Tx}, 32'h1);
      if (k == 100) check("d3_busy", {31'h0, Tx_Busy}, 32'h1);
    end
    check("d3_wave", bad_tx, 0);
    tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    @(negedge SysClk);
    check("rst_mid_tx", {31'h0, Tx}, 32'h1);
    check("rst_mid_busy", {31'h0, Tx_Busy}, 32'h0);
    check("rst_mid_ready", {31'h0, Tx_Ready}, 32'h1);
    check("rst_mid_rx_valid", {31'h0, Rx_Valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
